// File: rtl/prog_loader.sv
// Boot loader: takes a LEN/payload/CSUM byte frame, writes it to RAM, reads it back and verifies it.
// Latency: 1+2N+1+2N cycles from start to done for an unstalled N-byte frame.
// Backpressure: in_ready is high only in LEN/DATA/CSUM; bytes offered at other times are left unconsumed.
module prog_loader #(
    parameter int DEPTH = 128,
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int BASE  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [AW-1:0] A,
    output logic [DW-1:0] wdata,
    input  logic [DW-1:0] rdata,
    output logic          ram_en_bar,
    output logic          we_bar,
    output logic          re_bar,
    output logic          cpu_hold,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code
);

    typedef enum logic [3:0] {
        IDLE, LEN, DATA, WRITE, CSUM, VRD, VCMP, DONE, ERR
    } state_t;

    localparam logic [AW-1:0] BASE_A = AW'(BASE);
    localparam logic [DW:0]   MAXLEN = (DW+1)'(DEPTH - BASE);

    state_t        state;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] sum;
    logic [DW-1:0] vsum;
    logic [DW-1:0] len;
    logic [DW-1:0] count;
    logic [1:0]    err_code_q;

    logic          xfer;
    logic          len_bad;
    logic [DW-1:0] sum_next;
    logic [DW-1:0] vsum_next;
    logic [DW-1:0] cnt_next;

    assign xfer      = in_valid & in_ready;
    // A frame must fit between BASE and the top of memory.
    assign len_bad   = (in_data == '0) || ({1'b0, in_data} > MAXLEN);
    assign sum_next  = sum + in_data;
    assign vsum_next = vsum + rdata;
    assign cnt_next  = count + DW'(1);

    // Strobes and status are pure decodes of the state register.
    assign in_ready   = (state == LEN) || (state == DATA) || (state == CSUM);
    assign ram_en_bar = !((state == WRITE) || (state == VRD));
    assign we_bar     = (state != WRITE);
    assign re_bar     = (state != VRD);
    assign A          = addr;
    assign wdata      = wdata_q;
    assign cpu_hold   = (state != DONE);
    assign done       = (state == DONE);
    assign err        = (state == ERR);
    assign err_code   = err_code_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            wdata_q    <= '0;
            sum        <= '0;
            vsum       <= '0;
            len        <= '0;
            count      <= '0;
            err_code_q <= 2'd0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= LEN;
                        sum        <= '0;
                        count      <= '0;
                        addr       <= BASE_A;
                        err_code_q <= 2'd0;
                    end
                end
                LEN: begin
                    if (xfer) begin
                        len <= in_data;
                        sum <= in_data;
                        if (len_bad) begin
                            state      <= ERR;
                            err_code_q <= 2'd1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        wdata_q <= in_data;
                        sum     <= sum_next;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    addr  <= addr + AW'(1);
                    count <= cnt_next;
                    state <= (cnt_next == len) ? CSUM : DATA;
                end
                CSUM: begin
                    if (xfer) begin
                        sum <= sum_next;
                        if (sum_next != '0) begin
                            state      <= ERR;
                            err_code_q <= 2'd2;
                        end else begin
                            addr  <= BASE_A;
                            count <= '0;
                            vsum  <= len + in_data;
                            state <= VRD;
                        end
                    end
                end
                VRD: begin
                    state <= VCMP;
                end
                VCMP: begin
                    // rdata carries the byte strobed in the preceding VRD cycle.
                    vsum  <= vsum_next;
                    addr  <= addr + AW'(1);
                    count <= cnt_next;
                    if (cnt_next < len) begin
                        state <= VRD;
                    end else if (vsum_next != '0) begin
                        state      <= ERR;
                        err_code_q <= 2'd3;
                    end else begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader: the initiator that fills the processor's 8x128 memory before the core runs.
- Accepts a framed byte stream over a valid/ready handshake and writes each payload byte through the active-low memory strobe interface (ram_en_bar / we_bar / re_bar).
- Reads the image back and checks it against the frame checksum.
- Holds the core in reset via cpu_hold until a verified image is in memory.

Parameters:
- DEPTH, 128, number of memory locations; maximum payload length.
- AW, 8, memory address width.
- DW, 8, data width.
- BASE, 0, first memory address written.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load. Honoured only in IDLE, DONE and ERR.
- in_data  input  DW  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte.
- A  output  AW  memory address.
- wdata  output  DW  memory write data.
- rdata  input  DW  memory read data; registered by memory, valid the cycle after a read strobe.
- ram_en_bar  output  1  memory enable, active low.
- we_bar  output  1  write strobe, active low.
- re_bar  output  1  read strobe, active low.
- cpu_hold  output  1  1 = core held in reset.
- done  output  1  verified image loaded.
- err  output  1  load failed.
- err_code  output  2  0 none, 1 length, 2 checksum, 3 verify.

Behaviour:
- Frame format: LEN byte (N), then N payload bytes, then CSUM byte. The frame is valid when (LEN + sum of payload + CSUM) mod 256 = 0.
- Reset values: state=IDLE, in_ready=0, A=0, wdata=0, ram_en_bar=1, we_bar=1, re_bar=1, cpu_hold=1, done=0, err=0, err_code=0, internal sum=0, count=0.
- Strobes, A and wdata are decoded from the state register and registered address/data. They are stable for the whole cycle.
- Strobes are mutually exclusive; re_bar and we_bar are never low in the same cycle.
- Byte transfer occurs on any cycle with in_valid & in_ready. in_ready=1 only in LEN, DATA and CSUM.
- IDLE: start -> LEN; clears sum, count, addr=BASE, err, err_code, done; cpu_hold=1.
- LEN: on transfer, N=in_data and sum=in_data.
  - N=0 or N>DEPTH -> ERR with err_code=1.
  - Otherwise -> DATA.
- DATA: on transfer, latch wdata=in_data, add it to sum, go to WRITE.
- WRITE: exactly one cycle with ram_en_bar=0, we_bar=0, re_bar=1, A=addr; in_ready=0. Then addr+1 and count+1.
  - If count+1=N -> CSUM.
  - Otherwise -> DATA.
- CSUM: on transfer, sum+=in_data.
  - If the result is nonzero -> ERR with err_code=2.
  - Otherwise addr=BASE, count=0, vsum=N+CSUM -> VRD.
- VRD: one cycle with ram_en_bar=0, re_bar=0, we_bar=1, A=addr -> VCMP.
- VCMP: all strobes high; vsum+=rdata, addr+1, count+1.
  - If count+1<N -> VRD.
  - Else, if vsum+rdata is nonzero -> ERR with err_code=3; otherwise -> DONE.
- Verify cost: 2 cycles per byte.
- DONE: done=1, cpu_hold=0; state holds. start -> LEN (reload; cpu_hold=1 and done=0 from the next cycle).
- ERR: err=1, cpu_hold=1; state holds. start -> LEN and clears err/err_code.
- Address arithmetic: addr wraps mod 2^AW. BASE+N-1 must not exceed DEPTH-1. If BASE+N>DEPTH -> ERR with err_code=1 at the LEN check.
- Sums are 8-bit modular.
- start while busy (LEN..VCMP) is ignored.
- in_valid while in_ready=0 is ignored; the byte is not consumed.
- Reset mid-operation: all outputs return to reset values on the next clock. Memory contents already written are not cleared.
- The WRITE strobe is never shortened or split.
- Minimum load time for N bytes: 1+2N+1+2N cycles after start, excluding stream stalls.

Test Plan:
- Nominal load: start; stream 03,11,22,33,97 with in_valid held high; RAM model.
  - Expect three single-cycle writes: A=0/1/2, wdata=11/22/33.
  - Expect three reads.
  - Expect done=1, cpu_hold=0, err=0.
- Checksum error: stream 03,11,22,33,98.
  - Expect three writes, no reads.
  - Expect err=1, err_code=2, cpu_hold=1, done=0.
- Length error: stream 00, and separately 81 (129).
  - Expect ERR with err_code=1 immediately; zero write strobes; in_ready=0 afterwards.
- Verify failure: nominal frame; RAM model corrupts address 1 on readback (22 -> 23).
  - Expect err=1, err_code=3.
- Backpressure: random in_valid gaps during the nominal frame.
  - Expect identical memory contents.
  - Expect in_ready=0 in every WRITE/VRD/VCMP cycle.
  - Expect no byte lost or duplicated.
- Reset mid-load: assert rst during the second WRITE.
  - Next cycle: all strobes high, cpu_hold=1, state IDLE.
  - A following start plus the full nominal frame ends in done=1.
